// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory serving 8-byte requests with a fixed latency.
// Optional macro DMEM_ALIGN_CHECK_EN: flags accesses with addr[2:0] != 0 as errors.
module dmem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_error_o
);
  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_OK  = 64'(MEM_BYTES - 8);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        write_reg, write_next;
  logic [63:0] addr_reg, addr_next;
  logic [63:0] wdata_reg, wdata_next;
  logic [63:0] rdata_reg, rdata_next;
  logic        error_reg, error_next;

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] base_idx;
  logic [63:0]   rd_word;
  logic          access_err;
  logic          do_access;

  assign base_idx = addr_reg[AW-1:0];

  // Full 64-bit compare so huge addresses never alias back into the array.
`ifdef DMEM_ALIGN_CHECK_EN
  assign access_err = (addr_reg > LAST_OK) || (addr_reg[2:0] != 3'd0);
`else
  assign access_err = (addr_reg > LAST_OK);
`endif

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign rd_word[8*gi +: 8] = mem[base_idx + AW'(gi)];
  end

  assign do_access = (state_reg == BUSY) && (cnt_reg == 4'd0);

  always_ff @(posedge clk_i) begin
    if (do_access && write_reg && !access_err) begin
      for (int i = 0; i < 8; i++) begin
        mem[base_idx + AW'(i)] <= wdata_reg[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      write_reg <= 1'b0;
      addr_reg  <= 64'd0;
      wdata_reg <= 64'd0;
      rdata_reg <= 64'd0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      write_reg <= write_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    error_next = error_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
          write_next = req_write_i;
          addr_next  = req_addr_i;
          wdata_next = req_wdata_i;
          cnt_next   = CNT_INIT;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          error_next = access_err;
          rdata_next = (access_err || write_reg) ? 64'd0 : rd_word;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_next = IDLE;
          rdata_next = 64'd0;
          error_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready_o  = (state_reg == IDLE);
  assign resp_valid_o = (state_reg == RESP);
  assign resp_rdata_o = rdata_reg;
  assign resp_error_o = error_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed corner cases followed by randomized
// traffic checked against a byte-array reference model of the memory.
module tb_dmem_responder;
  localparam int MEMB = 1024;
  localparam int LAT  = 2;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [63:0] req_addr_i = 64'd0;
  logic [63:0] req_wdata_i = 64'd0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [63:0] resp_rdata_o;
  logic        resp_error_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] mm [MEMB];

  dmem_responder #(.MEM_BYTES(MEMB), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_error_o(resp_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic [63:0] a);
    logic e;
    e = (a > 64'(MEMB - 8));
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[2:0] != 3'd0) e = 1'b1;
`endif
    return e;
  endfunction

  // Issue one request from an IDLE point (#1 after an edge) and retire it after 'hold' stall cycles.
  task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] wd, input int hold,
                     input string tag, output logic [63:0] rd, output logic er);
    int lat;
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = a; req_wdata_i = wd;
    @(posedge clk_i); #1;
    // Junk request stays asserted while busy; it must be ignored.
    req_write_i = 1'b1; req_addr_i = 64'h40; req_wdata_i = {$urandom, $urandom};
    lat = 0;
    while (resp_valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    rd = resp_rdata_o;
    er = resp_error_o;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_i); #1;
      chk({tag, "_hold_valid"}, 64'(resp_valid_o), 64'd1);
      chk({tag, "_hold_ready"}, 64'(req_ready_o), 64'd0);
      chk({tag, "_hold_rdata"}, resp_rdata_o, rd);
      chk({tag, "_hold_err"}, 64'(resp_error_o), 64'(er));
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk({tag, "_post_valid"}, 64'(resp_valid_o), 64'd0);
    chk({tag, "_post_ready"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_post_rdata"}, resp_rdata_o, 64'd0);
    chk({tag, "_post_err"}, 64'(resp_error_o), 64'd0);
  endtask

  task automatic op(input logic wr, input logic [63:0] a, input logic [63:0] wd, input int hold,
                    input string tag, output logic [63:0] rd);
    logic er, e_err;
    logic [63:0] e_rd;
    e_err = is_err(a);
    e_rd = 64'd0;
    if (!wr && !e_err)
      for (int i = 0; i < 8; i++) e_rd[8*i +: 8] = mm[int'(a[31:0]) + i];
    txn(wr, a, wd, hold, tag, rd, er);
    chk({tag, "_err"}, 64'(er), 64'(e_err));
    chk({tag, "_rdata"}, rd, e_rd);
    if (wr && !e_err)
      for (int i = 0; i < 8; i++) mm[int'(a[31:0]) + i] = wd[8*i +: 8];
    $display("txn %s wr=%0d addr=%h wdata=%h rdata=%h err=%0d", tag, wr, a, wd, rd, er);
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] a;
    logic        wr;

    // Reset values
    #2;
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_rdata", resp_rdata_o, 64'd0);
    chk("rst_err", 64'(resp_error_o), 64'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Basic write/read and little-endian byte placement
    op(1'b1, 64'h10, 64'h0123456789ABCDEF, 0, "wr10", rd);
    op(1'b1, 64'h18, 64'h1122334455667788, 0, "wr18", rd);
    op(1'b0, 64'h10, 64'd0, 0, "rd10", rd);
    chk("rd10_const", rd, 64'h0123456789ABCDEF);
    chk("byte_0x10", 64'(rd[7:0]), 64'hEF);
    chk("byte_0x17", 64'(rd[63:56]), 64'h01);

    // Upper boundary
    op(1'b0, 64'd1017, 64'd0, 0, "rd1017", rd);
    op(1'b1, 64'd1016, 64'hA5A5_5A5A_DEAD_BEEF, 0, "wr1016", rd);
    op(1'b0, 64'd1016, 64'd0, 0, "rd1016", rd);
    chk("rd1016_const", rd, 64'hA5A5_5A5A_DEAD_BEEF);
    op(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, "rd_wrap", rd);

    // Rejected write must not touch memory
    op(1'b1, 64'h3F8, 64'h0F0E0D0C0B0A0908, 0, "wr3f8", rd);
    op(1'b1, 64'h3FF, 64'hFFFF_FFFF_FFFF_FFFF, 0, "wr3ff", rd);
    op(1'b0, 64'h3F8, 64'd0, 0, "rd3f8", rd);
    chk("rd3f8_const", rd, 64'h0F0E0D0C0B0A0908);

    // Response back-pressure
    op(1'b0, 64'h18, 64'd0, 5, "stall5", rd);

    // Reset while a write is in flight
    op(1'b1, 64'h20, 64'hCAFEF00D_12345678, 0, "wr20", rd);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 64'h20; req_wdata_i = 64'h1111_2222_3333_4444;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    #1;
    chk("arst_ready", 64'(req_ready_o), 64'd1);
    chk("arst_valid", 64'(resp_valid_o), 64'd0);
    chk("arst_rdata", resp_rdata_o, 64'd0);
    chk("arst_err", 64'(resp_error_o), 64'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    op(1'b0, 64'h20, 64'd0, 0, "rd20", rd);
    chk("rd20_const", rd, 64'hCAFEF00D_12345678);

    // Unaligned access
    op(1'b0, 64'h11, 64'd0, 0, "rd11", rd);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("rd11_const", rd, 64'd0);
`else
    chk("rd11_const", rd, 64'h8801234567_89ABCD);
`endif

    // Randomized traffic over a pre-filled window plus occasional out-of-range addresses
    for (int i = 0; i < 17; i++)
      op(1'b1, 64'(32'h100 + 8 * i), {$urandom, $urandom}, 0, "fill", rd);
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = {32'($urandom), 32'($urandom)} | 64'h400;
      else
        a = 64'($urandom_range(32'h100, 32'h180));
      op(wr, a, {$urandom, $urandom}, int'($urandom_range(0, 3)), "rand", rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
